alu_arbiter: RTL and testbench

Sequencing front-end that shares a single instance of the team's 32-bit combinational `alu` between two requesters. Each requester presents an operation on a valid/ready channel. A round-robin arbiter grants one request at a time and registers the operands. The block drives the ALU from those registers, then returns the result and flags on a single tagged response channel with back-pressure.

---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front-end sharing one 32-bit combinational ALU between
// two valid/ready requesters, with a tagged, back-pressured response channel.
// Optional per-requester accept counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_f,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_f,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        grant;
    logic        idle_ok;
    logic        accept;
    logic [31:0] a_q, b_q;
    logic [2:0]  f_q;
    logic        id_q;

    logic [32:0] sum;
    logic [31:0] alu_res;
    logic        alu_carry, alu_ovf, alu_err;

    // Round-robin choice: a lone requester always wins, contention alternates.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // rst_n gating keeps both readys low for the whole reset window.
    assign idle_ok    = rst_n && (state_q == StIdle);
    assign req0_ready = idle_ok && req0_valid && !grant;
    assign req1_ready = idle_ok && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        rsp_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
    end

    // Operand capture and round-robin history on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= ~PRIO_INIT;
        end else if (accept) begin
            a_q          <= grant ? req1_a : req0_a;
            b_q          <= grant ? req1_b : req0_b;
            f_q          <= grant ? req1_f : req0_f;
            id_q         <= grant;
            last_grant_q <= grant;
        end
    end

    // Shared ALU; SUB is a + ~b + 1 so carry means "no borrow".
    always_comb begin
        sum       = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (f_q)
            3'b000: begin
                sum       = {1'b0, a_q} + {1'b0, b_q};
                alu_res   = sum[31:0];
                alu_carry = sum[32];
                alu_ovf   = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
            end
            3'b001: begin
                sum       = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
                alu_res   = sum[31:0];
                alu_carry = sum[32];
                alu_ovf   = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
            end
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b101:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
            default: alu_err = 1'b1;
        endcase
    end

    // Response registers load in EXEC and hold through RESP back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_id     <= id_q;
            rsp_result <= alu_res;
            rsp_flags  <= {alu_res == 32'd0, alu_ovf, alu_carry, alu_res[31]};
            rsp_err    <= alu_err;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating per-requester accept counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = 16'h0000;
    assign grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [3:0]  flags;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt0 = 0;
    int   cnt1 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int c);
`ifdef ALU_ARB_STATS_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic rsp_t mk(input logic id, input logic [31:0] r, input logic [3:0] fl,
                                input logic e);
        rsp_t x;
        x.id = id; x.result = r; x.flags = fl; x.err = e;
        return x;
    endfunction

    // Reference ALU built from wide signed arithmetic and unsigned compares.
    function automatic rsp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f);
        rsp_t   r;
        longint sa, sb, sr;
        logic   c, v;
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0; v = 1'b0;
        r.id = id; r.err = 1'b0; r.result = '0;
        case (f)
            3'd0: begin
                sr = sa + sb;
                r.result = a + b;
                c = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                sr = sa - sb;
                r.result = a - b;
                c = (a >= b);
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: r.result = a & b;
            3'd3: r.result = a | b;
            3'd5: r.result = (sa < sb) ? 32'd1 : 32'd0;
            default: r.err = 1'b1;
        endcase
        r.flags = {r.result == 32'd0, v, c, r.result[31]};
        return r;
    endfunction

    // Present a request and wait (bounded) for its handshake; push the expectation.
    task automatic accept(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input rsp_t e);
        int n = 0;
        if (id) begin
            req1_a = a; req1_b = b; req1_f = f; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_f = f; req0_valid = 1'b1;
        end
        #1;
        while (((id ? req1_ready : req0_ready) !== 1'b1) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_ready", id ? req1_ready : req0_ready, 1);
        exp_q.push_back(e);
        if (id) cnt1++; else cnt0++;
        @(negedge clk);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Wait for a response, hold it for 'hold' cycles, then handshake and compare.
    task automatic get_rsp(input string tag, input int hold);
        rsp_t e;
        int   n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        n_checks++;
        assert (exp_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
            return;
        end
        e = exp_q[0];
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_result"}, rsp_result, e.result);
            chk({tag, "_hold_flags"}, rsp_flags, e.flags);
            chk({tag, "_hold_valid"}, rsp_valid, 1);
            chk({tag, "_hold_busy"}, busy, 1);
            chk({tag, "_hold_readys"}, {req0_ready, req1_ready}, 0);
            @(negedge clk);
        end
        e = exp_q.pop_front();
        chk({tag, "_id"}, rsp_id, e.id);
        chk({tag, "_result"}, rsp_result, e.result);
        chk({tag, "_flags"}, rsp_flags, e.flags);
        chk({tag, "_err"}, rsp_err, e.err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_drop_valid"}, rsp_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        cnt0 = 0; cnt1 = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        logic        rid;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req0_f = 0; req1_a = 0; req1_b = 0; req1_f = 0;
        repeat (2) @(negedge clk);

        // Reset state, with both valids raised to prove readys stay low.
        req0_valid = 1; req1_valid = 1; #1;
        chk("rst_readys", {req0_ready, req1_ready}, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", {rsp_id, rsp_result, rsp_flags, rsp_err}, 0);
        chk("rst_cnts", {grant_cnt0, grant_cnt1}, 0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Single ADD with latency check.
        accept(0, 32'd5, 32'd3, 3'b000, mk(0, 32'd8, 4'b0000, 0));
        chk("add_c1_valid", rsp_valid, 0);
        chk("add_c1_busy", busy, 1);
        @(negedge clk);
        chk("add_c2_valid", rsp_valid, 1);
        get_rsp("add", 0);
        chk("add_cnt0", grant_cnt0, exp_cnt(cnt0));

        // Contention: req0 wins first, then req1 wins even with req0 valid again.
        do_reset();
        req0_a = 3; req0_b = 5; req0_f = 3'b001; req0_valid = 1;
        req1_a = 1; req1_b = 1; req1_f = 3'b001; req1_valid = 1;
        #1;
        chk("cont_ready0", req0_ready, 1);
        chk("cont_ready1", req1_ready, 0);
        exp_q.push_back(mk(0, 32'hFFFF_FFFE, 4'b0001, 0));
        cnt0++;
        @(negedge clk);
        req0_a = 10; req0_b = 4; req0_f = 3'b010;
        get_rsp("cont0", 0);
        chk("rr_ready1", req1_ready, 1);
        chk("rr_ready0", req0_ready, 0);
        accept(1, 32'd1, 32'd1, 3'b001, mk(1, 32'd0, 4'b1010, 0));
        get_rsp("cont1", 0);
        accept(0, 32'd10, 32'd4, 3'b010, mk(0, 32'd0, 4'b1000, 0));
        get_rsp("and", 0);
        chk("cont_cnt0", grant_cnt0, exp_cnt(cnt0));
        chk("cont_cnt1", grant_cnt1, exp_cnt(cnt1));

        // ADD signed overflow.
        accept(0, 32'h7FFF_FFFF, 32'd1, 3'b000, mk(0, 32'h8000_0000, 4'b0101, 0));
        get_rsp("ovf", 0);

        // Back-pressure with req1 waiting behind it.
        accept(0, 32'd20, 32'd7, 3'b001, model(0, 32'd20, 32'd7, 3'b001));
        req1_a = 6; req1_b = 9; req1_f = 3'b101; req1_valid = 1;
        get_rsp("bp", 5);
        accept(1, 32'd6, 32'd9, 3'b101, mk(1, 32'd1, 4'b0000, 0));
        get_rsp("slt", 0);

        // Reset during EXEC discards the op.
        accept(0, 32'd100, 32'd200, 3'b000, model(0, 32'd100, 32'd200, 3'b000));
        chk("rexec_busy", busy, 1);
        req1_valid = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("rexec_rsp_valid", rsp_valid, 0);
        chk("rexec_busy0", busy, 0);
        chk("rexec_rsp", {rsp_id, rsp_result, rsp_flags, rsp_err}, 0);
        chk("rexec_readys", {req0_ready, req1_ready}, 0);
        chk("rexec_cnts", {grant_cnt0, grant_cnt1}, 0);
        req1_valid = 0;
        void'(exp_q.pop_back());
        cnt0 = 0; cnt1 = 0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rexec_no_rsp", rsp_valid, 0);
        end

        // Unsupported opcode.
        accept(0, 32'd9, 32'd9, 3'b111, mk(0, 32'd0, 4'b1000, 1));
        get_rsp("bad_op", 0);

        // Mixed random operations against the reference model.
        for (int i = 0; i < 10; i++) begin
            rid = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? ra : $urandom;
            rf  = 3'($urandom_range(0, 7));
            accept(rid, ra, rb, rf, model(rid, ra, rb, rf));
            get_rsp("rnd", 0);
        end
        chk("end_cnt0", grant_cnt0, exp_cnt(cnt0));
        chk("end_cnt1", grant_cnt1, exp_cnt(cnt1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
